// File: rtl/bp_pkg.sv
// Shared definitions for the branch target buffer predictor:
// field widths, counter encodings and PC slicing helpers.
package bp_pkg;

  localparam int PC_W = 32;

  // Entry record layout: valid, tag, counter, target.
  localparam int ENT_VALID_W  = 1;
  localparam int ENT_TARGET_W = PC_W;

  typedef logic [PC_W-1:0] addr_t;

  function automatic int entry_w(input int tag_w, input int cnt_w);
    return ENT_VALID_W + tag_w + cnt_w + ENT_TARGET_W;
  endfunction

  function automatic addr_t low_mask(input int w);
    return (addr_t'(1) << w) - addr_t'(1);
  endfunction

  // Word-aligned index: pc[idx_w+1:2].
  function automatic addr_t bp_index(input addr_t pc, input int idx_w);
    return (pc >> 2) & low_mask(idx_w);
  endfunction

  // Tag: pc[idx_w+tag_w+1:idx_w+2].
  function automatic addr_t bp_tag(input addr_t pc, input int idx_w,
                                   input int tag_w);
    return (pc >> (idx_w + 2)) & low_mask(tag_w);
  endfunction

  // Weakly taken: 100..0b.
  function automatic addr_t cnt_weak_taken(input int w);
    return addr_t'(1) << (w - 1);
  endfunction

  // Weakly not-taken: 011..1b.
  function automatic addr_t cnt_weak_not_taken(input int w);
    return cnt_weak_taken(w) - addr_t'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down next-value function with explicit load.
// Load wins over inc, inc wins over dec.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  // Next value, holding at all-ones and at zero.
  always_comb begin
    cnt_o = cnt_i;
    if (load_i) begin
      cnt_o = load_val_i;
    end else if (inc_i && (cnt_i != '1)) begin
      cnt_o = cnt_i + 1'b1;
    end else if (dec_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged BTB with per-entry saturating counters: zero-latency
// lookup from IF, trained by MEM, plus a mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_i,
  output logic              hit_o,
  output logic              predict_taken_o,
  output logic [31:0]       next_pc_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [31:0]       upd_target_i,
  input  logic              upd_mispredict_i,
  input  logic              clear_i,
  output logic [PERF_W-1:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WT =
    CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT =
    CNT_W'(cnt_weak_not_taken(CNT_W));

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];

  logic [PERF_W-1:0] perf_q;
  logic [PERF_W-1:0] perf_d;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic [CNT_W-1:0] wr_cnt;

  assign rd_idx = IDX_W'(bp_index(pc_i, IDX_W));
  assign rd_tag = TAG_W'(bp_tag(pc_i, IDX_W, TAG_W));
  assign wr_idx = IDX_W'(bp_index(upd_pc_i, IDX_W));
  assign wr_tag = TAG_W'(bp_tag(upd_pc_i, IDX_W, TAG_W));
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Lookup on registered state only; no bypass from the update port.
  always_comb begin
    hit_o           = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    predict_taken_o = hit_o && cnt_q[rd_idx][CNT_W-1];
    next_pc_o       = predict_taken_o ? tgt_q[rd_idx] : pc_i + 32'd4;
  end

  // A miss only reaches the table when taken, so it always loads weakly taken.
  sat_counter #(.W(CNT_W)) u_entry_cnt (
    .cnt_i      (cnt_q[wr_idx]),
    .inc_i      (upd_taken_i),
    .dec_i      (!upd_taken_i),
    .load_i     (!wr_hit),
    .load_val_i (CNT_WT),
    .cnt_o      (wr_cnt)
  );

  sat_counter #(.W(PERF_W)) u_perf_cnt (
    .cnt_i      (perf_q),
    .inc_i      (upd_valid_i && upd_mispredict_i),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (perf_d)
  );

  // Table next state: clear beats training.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        cnt_d[i]   = CNT_WNT;
      end
    end else if (upd_valid_i) begin
      if (wr_hit) begin
        cnt_d[wr_idx] = wr_cnt;
        if (upd_taken_i) tgt_d[wr_idx] = upd_target_i;
      end else if (upd_taken_i) begin
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = wr_tag;
        cnt_d[wr_idx]   = wr_cnt;
        tgt_d[wr_idx]   = upd_target_i;
      end
    end
  end

  // State registers with asynchronous reset of every entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
        tgt_q[i]   <= '0;
      end
      perf_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      perf_q  <= perf_d;
    end
  end

  assign mispredict_cnt_o = perf_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one task per scenario,
// hand-computed expectations, single summary line.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        predict_taken_o;
  logic [31:0] next_pc_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispredict_i;
  logic        clear_i;
  logic [15:0] mispredict_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .hit_o            (hit_o),
    .predict_taken_o  (predict_taken_o),
    .next_pc_o        (next_pc_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_mispredict_i (upd_mispredict_i),
    .clear_i          (clear_i),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic mis);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_taken_i      = tk;
    upd_target_i     = tgt;
    upd_mispredict_i = mis;
    @(posedge clk_i);
    #1;
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    pc_i  = 32'h40;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hit got %0b want 0", hit_o);
    end
    n_checks++;
    if (predict_taken_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_pt got %0b want 0", predict_taken_o);
    end
    n_checks++;
    if (next_pc_o !== 32'h44) begin
      n_fail++; $display("FAIL reset_npc got %h want 00000044", next_pc_o);
    end
    n_checks++;
    if (mispredict_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h want 0000", mispredict_cnt_o);
    end
  endtask

  task automatic test_train();
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    pc_i = 32'h40;
    #1;
    n_checks++;
    if ({hit_o, predict_taken_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL train_hit_pt got %b want 11", {hit_o, predict_taken_o});
    end
    n_checks++;
    if (next_pc_o !== 32'h100) begin
      n_fail++; $display("FAIL train_npc got %h want 00000100", next_pc_o);
    end
  endtask

  task automatic test_counter();
    // 10 -> 01 -> 00
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    pc_i = 32'h40;
    #1;
    n_checks++;
    if ({hit_o, predict_taken_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL ctr_nt_hit_pt got %b want 10", {hit_o, predict_taken_o});
    end
    n_checks++;
    if (next_pc_o !== 32'h44) begin
      n_fail++; $display("FAIL ctr_nt_npc got %h want 00000044", next_pc_o);
    end
    // 00 -> 11 (saturated), then one not-taken -> 10
    for (int i = 0; i < 5; i++) upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    pc_i = 32'h40;
    #1;
    n_checks++;
    if (predict_taken_o !== 1'b1) begin
      n_fail++; $display("FAIL ctr_sat_pt got %0b want 1", predict_taken_o);
    end
    n_checks++;
    if (next_pc_o !== 32'h100) begin
      n_fail++; $display("FAIL ctr_sat_npc got %h want 00000100", next_pc_o);
    end
    // 10 -> 01: one more not-taken proves it was 10, not 11
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (predict_taken_o !== 1'b0) begin
      n_fail++; $display("FAIL ctr_after_sat_pt got %0b want 0", predict_taken_o);
    end
  endtask

  task automatic test_alias();
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    pc_i = 32'h80;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL alias_pre_hit got %0b want 0", hit_o);
    end
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    pc_i = 32'h40;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL alias_old_hit got %0b want 0", hit_o);
    end
    pc_i = 32'h80;
    #1;
    n_checks++;
    if (next_pc_o !== 32'h200) begin
      n_fail++; $display("FAIL alias_new_npc got %h want 00000200", next_pc_o);
    end
    upd(32'h0C0, 1'b0, 32'h300, 1'b0);
    pc_i = 32'h80;
    #1;
    n_checks++;
    if ({hit_o, predict_taken_o, next_pc_o} !== {2'b11, 32'h200}) begin
      n_fail++;
      $display("FAIL alias_keep got %b/%b/%h want 1/1/00000200",
               hit_o, predict_taken_o, next_pc_o);
    end
    pc_i = 32'h0C0;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL alias_c0_hit got %0b want 0", hit_o);
    end
  endtask

  task automatic test_same_cycle();
    do_clear();
    pc_i             = 32'h40;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 32'h40;
    upd_taken_i      = 1'b1;
    upd_target_i     = 32'h100;
    upd_mispredict_i = 1'b0;
    #1;
    n_checks++;
    if (hit_o !== 1'b0 || next_pc_o !== 32'h44) begin
      n_fail++;
      $display("FAIL sc_lookup_old got %0b/%h want 0/00000044",
               hit_o, next_pc_o);
    end
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    n_checks++;
    if (hit_o !== 1'b1 || next_pc_o !== 32'h100) begin
      n_fail++;
      $display("FAIL sc_lookup_new got %0b/%h want 1/00000100",
               hit_o, next_pc_o);
    end
    clear_i          = 1'b1;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 32'h80;
    upd_taken_i      = 1'b1;
    upd_target_i     = 32'h200;
    upd_mispredict_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i          = 1'b0;
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
    pc_i = 32'h40;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL sc_clear_40 got %0b want 0", hit_o);
    end
    pc_i = 32'h80;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL sc_clear_80 got %0b want 0", hit_o);
    end
    n_checks++;
    if (mispredict_cnt_o !== 16'h1) begin
      n_fail++; $display("FAIL sc_clear_cnt got %h want 0001", mispredict_cnt_o);
    end
    // Cleared counters are weakly not-taken; a re-allocation still
    // loads weakly taken, one not-taken then drops below threshold.
    upd(32'h40, 1'b1, 32'h180, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    pc_i = 32'h40;
    #1;
    n_checks++;
    if ({hit_o, predict_taken_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL sc_realloc got %b want 10", {hit_o, predict_taken_o});
    end
  endtask

  task automatic test_wrap();
    pc_i = 32'hFFFF_FFFC;
    #1;
    n_checks++;
    if (next_pc_o !== 32'h0) begin
      n_fail++; $display("FAIL wrap_npc got %h want 00000000", next_pc_o);
    end
  endtask

  task automatic test_perf_sat();
    // Count is 1 here; 65533 more reach 0xFFFE.
    upd_valid_i      = 1'b1;
    upd_pc_i         = 32'h1000;
    upd_taken_i      = 1'b0;
    upd_target_i     = 32'h0;
    upd_mispredict_i = 1'b1;
    for (int i = 0; i < 65533; i++) @(posedge clk_i);
    #1;
    n_checks++;
    if (mispredict_cnt_o !== 16'hFFFE) begin
      n_fail++; $display("FAIL perf_pre_sat got %h want fffe", mispredict_cnt_o);
    end
    for (int i = 0; i < 4466; i++) @(posedge clk_i);
    #1;
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
    n_checks++;
    if (mispredict_cnt_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL perf_sat got %h want ffff", mispredict_cnt_o);
    end
    // mispredict flag without upd_valid_i must not count
    upd_mispredict_i = 1'b1;
    @(posedge clk_i);
    #1;
    upd_mispredict_i = 1'b0;
    n_checks++;
    if (mispredict_cnt_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL perf_hold got %h want ffff", mispredict_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    pc_i = 32'h40;
    #1;
    n_checks++;
    if (hit_o !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre_hit got %0b want 1", hit_o);
    end
    @(negedge clk_i);
    #1;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h80;
    upd_taken_i  = 1'b1;
    upd_target_i = 32'h200;
    rst_i        = 1'b1;
    #1;
    n_checks++;
    if ({hit_o, predict_taken_o, next_pc_o, mispredict_cnt_o}
        !== {2'b00, 32'h44, 16'h0}) begin
      n_fail++;
      $display("FAIL ar_now got %b/%b/%h/%h want 0/0/00000044/0000",
               hit_o, predict_taken_o, next_pc_o, mispredict_cnt_o);
    end
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    rst_i       = 1'b0;
    pc_i        = 32'h80;
    #1;
    n_checks++;
    if (hit_o !== 1'b0) begin
      n_fail++; $display("FAIL ar_drop_hit got %0b want 0", hit_o);
    end
  endtask

  initial begin
    rst_i            = 1'b1;
    pc_i             = 32'h0;
    upd_valid_i      = 1'b0;
    upd_pc_i         = 32'h0;
    upd_taken_i      = 1'b0;
    upd_target_i     = 32'h0;
    upd_mispredict_i = 1'b0;
    clear_i          = 1'b0;
    test_reset();
    test_train();
    test_counter();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_perf_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor (tagged branch target buffer with per-entry saturating counters) for the next-generation 5-stage pipe CPU. It sits beside the PC in IF and supplies the predicted next PC in the same cycle. It is trained by the branch-resolution stage (MEM), which replaces the static predict-not-taken, flush-on-taken behaviour of the current pipeline. It also keeps a saturating mispredict count for performance measurement.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry
- CNT_W, 2, saturating-counter width (≥2)
- PERF_W, 16, mispredict counter width

Ports:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_i  in  32  IF-stage PC to look up
- hit_o  out  1  valid entry whose tag matches pc_i
- predict_taken_o  out  1  hit_o AND counter MSB
- next_pc_o  out  32  predict_taken_o ? stored target : pc_i+4
- upd_valid_i  in  1  MEM stage resolved a branch this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  32  actual taken target
- upd_mispredict_i  in  1  pipeline detected a mispredict; qualified by upd_valid_i
- clear_i  in  1  synchronous invalidate-all (context switch / self-modifying code)
- mispredict_cnt_o  out  PERF_W  saturating mispredict count

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Bits [1:0] are ignored.
- Entry fields: valid, tag, counter (CNT_W), target (32).
- Lookup is purely combinational on the registered table: hit = valid && tag match.
- Update when upd_valid_i, at the entry indexed by upd_pc_i:
  - Tag hit: counter +1 if taken, −1 if not taken, saturating at 0 and 2^CNT_W−1. Target is overwritten only when taken.
  - Tag miss and taken: allocate and replace the entry. Set valid=1, write tag, set counter to weakly taken (100…0b), write target.
  - Tag miss and not taken: no change.
- mispredict_cnt_o increments when upd_valid_i && upd_mispredict_i and saturates at all-ones.
- clear_i clears every valid bit and resets every counter to weakly not-taken (011…1b). It does not touch mispredict_cnt_o.
- Priority: rst_i > clear_i > update. clear_i with upd_valid_i in the same cycle leaves the table cleared. The mispredict count still increments in that cycle.
- Reset values:
  - All valid=0.
  - Counters = weakly not-taken.
  - Tags and targets = 0.
  - mispredict_cnt_o = 0.
  - As a consequence, hit_o=0, predict_taken_o=0, next_pc_o=pc_i+4.

## Timing
- Lookup latency is 0 cycles (combinational from pc_i). Update latency is 1 cycle: a write takes effect at the clock edge and is visible to lookups in the following cycle.
- A lookup and an update to the same index in the same cycle: the lookup returns pre-update contents. There is no write-through bypass.
- There is no backpressure. An update is accepted every cycle.
- rst_i asserted mid-operation clears state immediately, without waiting for a clock edge. An update in flight is dropped.
- pc_i+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).

## Structure
- Shared package bp_pkg holds:
  - CNT weakly-taken and weakly-not-taken constants, derived from CNT_W.
  - Index and tag slice functions.
  - The entry record layout (valid, tag, counter, target widths).
- One sub-module, sat_counter: a CNT_W-wide saturating up/down next-value function with an explicit load value. It is reused for the per-entry counters and for the PERF_W mispredict counter.
- The table is flop-based arrays, no memory macro, so asynchronous reset of every entry is possible.

## Test plan
All scenarios use defaults: ENTRIES=16, TAG_W=8, CNT_W=2.
- Reset, then pc_i=0x40 → hit_o=0, predict_taken_o=0, next_pc_o=0x44, mispredict_cnt_o=0.
- Update pc 0x40, taken, target 0x100. Next cycle pc_i=0x40 → hit_o=1, predict_taken_o=1, next_pc_o=0x100.
- From that state, two not-taken updates (counter 10→01→00) → predict_taken_o=0, next_pc_o=0x44. Then five taken updates → counter saturates at 11; one not-taken → still predicts taken.
- Aliasing: after training 0x40, lookup 0x80 (same index, different tag) → hit_o=0. A taken update at 0x80 with target 0x200 replaces the entry, so 0x40 → hit_o=0 and 0x80 → next_pc_o=0x200. A not-taken update at 0xC0 leaves the entry unchanged.
- Same-cycle hazards:
  - Lookup 0x40 concurrent with its first taken update → old result (miss); next cycle → hit.
  - clear_i concurrent with upd_valid_i and upd_mispredict_i=1 → table empty, mispredict_cnt_o=1.
- Counter and reset: drive 70000 mispredict updates → mispredict_cnt_o holds 0xFFFF. Asserting rst_i between clock edges → all outputs return to reset values immediately.
